// File: rtl/joy_scan_arbiter.sv
// Joystick shift-register chain scanner with frame-boundary arbitration
// between the internal scanner and an external (MCU) requester.
module joy_scan_arbiter #(
  parameter int unsigned CLK_DIV   = 50,
  parameter int unsigned JBITS     = 12,
  parameter int unsigned GAP_TICKS = 16
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  output logic             JOY_CLK,
  output logic             JOY_LOAD_N,
  input  logic             JOY_DATA,
  input  logic             XJOY_CLK,
  input  logic             XJOY_LOAD_N,
  output logic             XJOY_DATA,
  input  logic             EXT_REQ,
  output logic             EXT_GNT,
  output logic [JBITS-1:0] JOY1,
  output logic [JBITS-1:0] JOY2,
  output logic             VALID
);

  localparam int unsigned NBITS = 2 * JBITS;
  localparam int unsigned TCW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BCW   = $clog2(NBITS + 1);
  localparam int unsigned GCW   = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  typedef enum logic [2:0] {
    ST_ARB,
    ST_LOAD,
    ST_SAMPLE,
    ST_CLKH,
    ST_DONE,
    ST_GAP
  } state_t;

  state_t           state, state_n;
  logic [TCW-1:0]   tick_cnt;
  logic             tick;
  logic [BCW-1:0]   bit_cnt, bit_cnt_n;
  logic [GCW-1:0]   gap_cnt, gap_cnt_n;
  logic [NBITS-1:0] sr, sr_n;
  logic             gnt_q, gnt_n;
  logic             pin_clk_q;
  logic             pin_load_n_q;

  assign tick = (tick_cnt == TCW'(CLK_DIV - 1));

  // Free-running scan tick divider, independent of FSM state.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TCW'(1);
    end
  end

  // State, counters, shift data, grant and registered pin/word outputs.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= ST_ARB;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      sr           <= '0;
      gnt_q        <= 1'b0;
      pin_clk_q    <= 1'b0;
      pin_load_n_q <= 1'b1;
      VALID        <= 1'b0;
      JOY1         <= '0;
      JOY2         <= '0;
    end else begin
      state        <= state_n;
      bit_cnt      <= bit_cnt_n;
      gap_cnt      <= gap_cnt_n;
      sr           <= sr_n;
      gnt_q        <= gnt_n;
      pin_clk_q    <= (state_n == ST_CLKH);
      pin_load_n_q <= (state_n != ST_LOAD);
      VALID        <= (state_n == ST_DONE);
      // Words and VALID both become visible in the DONE cycle.
      if (state_n == ST_DONE) begin
        JOY1 <= ~sr[NBITS-1:JBITS];
        JOY2 <= ~sr[JBITS-1:0];
      end
    end
  end

  // Next-state logic; everything except DONE waits for a tick.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    sr_n      = sr;
    gnt_n     = gnt_q;
    case (state)
      ST_ARB: begin
        if (tick) begin
          gnt_n = EXT_REQ;
          if (!EXT_REQ) begin
            state_n = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (tick) begin
          bit_cnt_n = '0;
          state_n   = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (tick) begin
          sr_n    = {sr[NBITS-2:0], JOY_DATA};
          state_n = ST_CLKH;
        end
      end
      ST_CLKH: begin
        if (tick) begin
          bit_cnt_n = bit_cnt + BCW'(1);
          if (bit_cnt == BCW'(NBITS - 1)) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_SAMPLE;
          end
        end
      end
      ST_DONE: begin
        gap_cnt_n = '0;
        state_n   = ST_GAP;
      end
      ST_GAP: begin
        if (tick) begin
          if (gap_cnt == GCW'(GAP_TICKS - 1)) begin
            state_n = ST_ARB;
          end else begin
            gap_cnt_n = gap_cnt + GCW'(1);
          end
        end
      end
      default: begin
        state_n = ST_ARB;
      end
    endcase
  end

  // Pin ownership mux; data always passes through to the requester.
  assign JOY_CLK    = gnt_q ? XJOY_CLK    : pin_clk_q;
  assign JOY_LOAD_N = gnt_q ? XJOY_LOAD_N : pin_load_n_q;
  assign XJOY_DATA  = JOY_DATA;
  assign EXT_GNT    = gnt_q;

endmodule

// File: tb/tb_joy_scan_arbiter.sv
// Self-checking bench for joy_scan_arbiter with a 74HC165-style chain model.
module tb_joy_scan_arbiter;

  localparam int unsigned CLK_DIV   = 2;
  localparam int unsigned JBITS     = 12;
  localparam int unsigned GAP_TICKS = 2;
  localparam int unsigned NB        = 2 * JBITS;
  // From the DONE cycle: GAP_TICKS ticks of gap plus one ARB tick.
  localparam int GAP_LEAD = int'((GAP_TICKS + 1) * CLK_DIV);

  logic             CLOCK_50 = 1'b0;
  logic             RESET_N  = 1'b0;
  logic             JOY_DATA;
  logic             XJOY_CLK    = 1'b0;
  logic             XJOY_LOAD_N = 1'b1;
  logic             EXT_REQ     = 1'b0;
  logic             JOY_CLK, JOY_LOAD_N, XJOY_DATA, EXT_GNT, VALID;
  logic [JBITS-1:0] JOY1, JOY2;

  int n_cmp = 0;
  int n_err = 0;

  // Chain model state: parallel word and number of shift edges since load.
  logic [NB-1:0] chain_word = '1;
  int            k = 0;
  logic          prev_pin_clk = 1'b0;

  joy_scan_arbiter #(
    .CLK_DIV  (CLK_DIV),
    .JBITS    (JBITS),
    .GAP_TICKS(GAP_TICKS)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET_N    (RESET_N),
    .JOY_CLK    (JOY_CLK),
    .JOY_LOAD_N (JOY_LOAD_N),
    .JOY_DATA   (JOY_DATA),
    .XJOY_CLK   (XJOY_CLK),
    .XJOY_LOAD_N(XJOY_LOAD_N),
    .XJOY_DATA  (XJOY_DATA),
    .EXT_REQ    (EXT_REQ),
    .EXT_GNT    (EXT_GNT),
    .JOY1       (JOY1),
    .JOY2       (JOY2),
    .VALID      (VALID)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // 74HC165 behaviour: load on LOAD_N low, shift on JOY_CLK rising, serial-in high.
  always @(negedge CLOCK_50) begin
    if (!JOY_LOAD_N) begin
      k = 0;
    end else if (JOY_CLK && !prev_pin_clk) begin
      k = k + 1;
    end
    prev_pin_clk = JOY_CLK;
    JOY_DATA = (k < int'(NB)) ? chain_word[NB-1-k] : 1'b1;
  end

  function automatic logic [JBITS-1:0] exp_j1(input logic [NB-1:0] w);
    return ~w[NB-1:JBITS];
  endfunction

  function automatic logic [JBITS-1:0] exp_j2(input logic [NB-1:0] w);
    return ~w[JBITS-1:0];
  endfunction

  task automatic step();
    @(negedge CLOCK_50);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!VALID && n < 600) begin
      step();
      n++;
    end
    if (!VALID) begin
      n_cmp++; n_err++;
      $display("FAIL %s: VALID not seen within 600 cycles", name);
    end
  endtask

  // Wait for a fresh internal LOAD, then for the chain to reach shift count n.
  task automatic wait_k(input string name, input int n);
    int c;
    c = 0;
    while (!(JOY_LOAD_N == 1'b0 && EXT_GNT == 1'b0) && c < 600) begin
      step();
      c++;
    end
    while (k != n && c < 1200) begin
      step();
      c++;
    end
    if (k != n) begin
      n_cmp++; n_err++;
      $display("FAIL %s: chain never reached bit %0d", name, n);
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    EXT_REQ = 1'b0;
    repeat (3) step();
    n_cmp++; if (JOY_LOAD_N !== 1'b1) begin n_err++; $display("FAIL reset_load_n: got %b want 1", JOY_LOAD_N); end
    n_cmp++; if (JOY_CLK !== 1'b0) begin n_err++; $display("FAIL reset_clk: got %b want 0", JOY_CLK); end
    n_cmp++; if (JOY1 !== '0) begin n_err++; $display("FAIL reset_joy1: got %h want 000", JOY1); end
    n_cmp++; if (JOY2 !== '0) begin n_err++; $display("FAIL reset_joy2: got %h want 000", JOY2); end
    n_cmp++; if (VALID !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", VALID); end
    n_cmp++; if (EXT_GNT !== 1'b0) begin n_err++; $display("FAIL reset_gnt: got %b want 0", EXT_GNT); end
  endtask

  task automatic test_frame_timing();
    int nload, load_run, first_i, second_i, pulses, cur_w, bad_w, nvalid, valid_i;
    logic prev_low, prev_hi;
    logic [JBITS-1:0] j1, j2;
    nload = 0; load_run = 0; first_i = -1; second_i = -1;
    pulses = 0; cur_w = 0; bad_w = 0; nvalid = 0; valid_i = -1;
    prev_low = 1'b0; prev_hi = 1'b0; j1 = '0; j2 = '0;
    chain_word = 24'hFFE7FE;
    RESET_N = 1'b1;
    for (int i = 1; i <= 600 && second_i < 0; i++) begin
      step();
      if (!JOY_LOAD_N && !prev_low) begin
        nload++;
        if (nload == 1) first_i = i;
        if (nload == 2) second_i = i;
      end
      if (!JOY_LOAD_N && nload == 1) load_run++;
      if (JOY_CLK) begin
        cur_w++;
      end else if (prev_hi) begin
        pulses++;
        if (cur_w != int'(CLK_DIV)) bad_w++;
        cur_w = 0;
      end
      if (VALID && nload == 1) begin
        nvalid++;
        valid_i = i;
        j1 = JOY1;
        j2 = JOY2;
      end
      prev_low = !JOY_LOAD_N;
      prev_hi  = JOY_CLK;
    end
    n_cmp++; if (first_i != int'(CLK_DIV)) begin n_err++; $display("FAIL first_load_at: got %0d want %0d", first_i, CLK_DIV); end
    n_cmp++; if (load_run != int'(CLK_DIV)) begin n_err++; $display("FAIL load_width: got %0d want %0d", load_run, CLK_DIV); end
    n_cmp++; if (pulses != int'(NB)) begin n_err++; $display("FAIL clk_pulses: got %0d want %0d", pulses, NB); end
    n_cmp++; if (bad_w != 0) begin n_err++; $display("FAIL clk_width: got %0d bad pulses want 0", bad_w); end
    n_cmp++; if (nvalid != 1) begin n_err++; $display("FAIL valid_count: got %0d want 1", nvalid); end
    n_cmp++;
    if (valid_i != first_i + int'(CLK_DIV * (1 + 2 * NB))) begin
      n_err++; $display("FAIL valid_at: got %0d want %0d", valid_i, first_i + int'(CLK_DIV * (1 + 2 * NB)));
    end
    n_cmp++;
    if (second_i - valid_i != GAP_LEAD) begin
      n_err++; $display("FAIL gap_to_load: got %0d want %0d", second_i - valid_i, GAP_LEAD);
    end
    n_cmp++; if (j1 !== exp_j1(24'hFFE7FE)) begin n_err++; $display("FAIL map_joy1: got %h want %h", j1, exp_j1(24'hFFE7FE)); end
    n_cmp++; if (j2 !== exp_j2(24'hFFE7FE)) begin n_err++; $display("FAIL map_joy2: got %h want %h", j2, exp_j2(24'hFFE7FE)); end
  endtask

  task automatic test_random_frames();
    logic [NB-1:0] w;
    w = chain_word;
    for (int f = 0; f < 6; f++) begin
      wait_k("rand_wait", 8);
      EXT_REQ = 1'b1;
      step();
      EXT_REQ = 1'b0;
      step();
      n_cmp++; if (EXT_GNT !== 1'b0) begin n_err++; $display("FAIL short_req_gnt: got %b want 0", EXT_GNT); end
      wait_valid("rand_valid");
      n_cmp++; if (JOY1 !== exp_j1(w)) begin n_err++; $display("FAIL rand_joy1 f%0d: got %h want %h", f, JOY1, exp_j1(w)); end
      n_cmp++; if (JOY2 !== exp_j2(w)) begin n_err++; $display("FAIL rand_joy2 f%0d: got %h want %h", f, JOY2, exp_j2(w)); end
      w = NB'($urandom);
      chain_word = w;
    end
  endtask

  task automatic test_arbitration();
    logic [NB-1:0] w;
    int early, vbad;
    early = 0; vbad = 0;
    w = chain_word;
    wait_k("arb_wait", 5);
    EXT_REQ = 1'b1;
    wait_valid("arb_valid");
    n_cmp++; if (JOY1 !== exp_j1(w)) begin n_err++; $display("FAIL arb_joy1: got %h want %h", JOY1, exp_j1(w)); end
    n_cmp++; if (JOY2 !== exp_j2(w)) begin n_err++; $display("FAIL arb_joy2: got %h want %h", JOY2, exp_j2(w)); end
    for (int j = 1; j < GAP_LEAD; j++) begin
      step();
      if (EXT_GNT !== 1'b0) early++;
    end
    n_cmp++; if (early != 0) begin n_err++; $display("FAIL gnt_early: got %0d cycles want 0", early); end
    step();
    n_cmp++; if (EXT_GNT !== 1'b1) begin n_err++; $display("FAIL gnt_after_gap: got %b want 1", EXT_GNT); end
    for (int t = 0; t < 16; t++) begin
      XJOY_CLK    = 1'($urandom);
      XJOY_LOAD_N = 1'($urandom);
      #2;
      n_cmp++;
      if (JOY_CLK !== XJOY_CLK || JOY_LOAD_N !== XJOY_LOAD_N || XJOY_DATA !== JOY_DATA) begin
        n_err++;
        $display("FAIL ext_mux t%0d: got clk=%b ld=%b xd=%b want clk=%b ld=%b xd=%b",
                 t, JOY_CLK, JOY_LOAD_N, XJOY_DATA, XJOY_CLK, XJOY_LOAD_N, JOY_DATA);
      end
      step();
      if (VALID !== 1'b0) vbad++;
    end
    for (int t = 0; t < 150; t++) begin
      step();
      if (VALID !== 1'b0) vbad++;
    end
    n_cmp++; if (vbad != 0) begin n_err++; $display("FAIL granted_valid: got %0d pulses want 0", vbad); end
    n_cmp++; if (JOY1 !== exp_j1(w)) begin n_err++; $display("FAIL granted_joy1: got %h want %h", JOY1, exp_j1(w)); end
    n_cmp++; if (JOY2 !== exp_j2(w)) begin n_err++; $display("FAIL granted_joy2: got %h want %h", JOY2, exp_j2(w)); end
  endtask

  task automatic test_release();
    logic [NB-1:0] w;
    int n;
    XJOY_CLK    = 1'b0;
    XJOY_LOAD_N = 1'b1;
    w = NB'($urandom);
    chain_word = w;
    EXT_REQ = 1'b0;
    n = 0;
    while (EXT_GNT && n <= int'(CLK_DIV)) begin
      step();
      n++;
    end
    n_cmp++; if (n < 1 || n > int'(CLK_DIV)) begin n_err++; $display("FAIL release_delay: got %0d cycles want 1..%0d", n, CLK_DIV); end
    n_cmp++; if (JOY_LOAD_N !== 1'b0) begin n_err++; $display("FAIL release_load: got %b want 0", JOY_LOAD_N); end
    wait_valid("release_valid");
    n_cmp++; if (JOY1 !== exp_j1(w)) begin n_err++; $display("FAIL release_joy1: got %h want %h", JOY1, exp_j1(w)); end
    n_cmp++; if (JOY2 !== exp_j2(w)) begin n_err++; $display("FAIL release_joy2: got %h want %h", JOY2, exp_j2(w)); end
  endtask

  task automatic test_reset_mid_shift();
    logic [NB-1:0] w;
    wait_k("rst_wait", 10);
    RESET_N = 1'b0;
    #1;
    n_cmp++; if (JOY_LOAD_N !== 1'b1) begin n_err++; $display("FAIL midrst_load_n: got %b want 1", JOY_LOAD_N); end
    n_cmp++; if (JOY_CLK !== 1'b0) begin n_err++; $display("FAIL midrst_clk: got %b want 0", JOY_CLK); end
    n_cmp++; if (JOY1 !== '0) begin n_err++; $display("FAIL midrst_joy1: got %h want 000", JOY1); end
    n_cmp++; if (JOY2 !== '0) begin n_err++; $display("FAIL midrst_joy2: got %h want 000", JOY2); end
    n_cmp++; if (VALID !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", VALID); end
    n_cmp++; if (EXT_GNT !== 1'b0) begin n_err++; $display("FAIL midrst_gnt: got %b want 0", EXT_GNT); end
    repeat (3) step();
    w = NB'($urandom);
    chain_word = w;
    RESET_N = 1'b1;
    wait_valid("midrst_valid");
    n_cmp++; if (JOY1 !== exp_j1(w)) begin n_err++; $display("FAIL midrst_new_joy1: got %h want %h", JOY1, exp_j1(w)); end
    n_cmp++; if (JOY2 !== exp_j2(w)) begin n_err++; $display("FAIL midrst_new_joy2: got %h want %h", JOY2, exp_j2(w)); end
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_random_frames();
    test_arbitration();
    test_release();
    test_reset_mid_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
